// File: rtl/jtdd_mcu_pkg.sv
// Shared types for the main/sub CPU bridge.
// Handshake state encoding and write-mode constants.
package jtdd_mcu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REQ     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_RELEASE = 2'd3
  } hs_state_t;

  localparam int MODE_HALT = 0;
  localparam int MODE_LIVE = 1;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port synchronous RAM, 1-clk read latency, old data on
// read-during-write. Ports: clk, addr/data/we/q per port.
module jtframe_dual_ram #(
  parameter int aw = 10,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic [aw-1:0] i_addr0,
  input  logic [dw-1:0] i_data0,
  input  logic          i_we0,
  output logic [dw-1:0] o_q0,
  input  logic [aw-1:0] i_addr1,
  input  logic [dw-1:0] i_data1,
  input  logic          i_we1,
  output logic [dw-1:0] o_q1
);

  logic [dw-1:0] r_mem [0:(1<<aw)-1];

  // port 1 is written last so it wins a same-address clash
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_addr0] <= i_data0;
    if (i_we1) r_mem[i_addr1] <= i_data1;
    o_q0 <= r_mem[i_addr0];
    o_q1 <= r_mem[i_addr1];
  end

endmodule

// File: rtl/jtdd_mcu_share.sv
// Main/sub CPU bridge: shared RAM, bus handshake, NMI, IRQ.
// Ports: main_* RAM/halt/NMI side, sub_* RAM/bus/IRQ side,
// cen times FSM and IRQ counter; halted flags bus grant.
module jtdd_mcu_share
  import jtdd_mcu_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MODE     = 0,
  parameter int IRQ_LEN  = 8,
  parameter int NMI_EDGE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] main_addr,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_wait,
  input  logic          main_halt,
  input  logic          main_nmi_set,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  input  logic          sub_nmi_ack,
  input  logic          sub_irq_req,
  input  logic          sub_busak_n,
  output logic          sub_busrq_n,
  output logic          sub_nmi_n,
  output logic          mcu_irqmain,
  output logic          halted
);

  localparam logic [7:0] LEN = 8'(IRQ_LEN);

  hs_state_t r_st, w_st_nxt;
  logic r_busrq_n, r_halted;
  logic w_busrq_n, w_halted;

  always_comb begin
    w_st_nxt = r_st;
    if (cen) begin
      unique case (r_st)
        ST_RUN:
          if (main_halt) w_st_nxt = ST_REQ;
        ST_REQ:
          if (!main_halt) w_st_nxt = ST_RUN;
          else if (!sub_busak_n) w_st_nxt = ST_HALTED;
        ST_HALTED:
          if (!main_halt) w_st_nxt = ST_RELEASE;
        ST_RELEASE:
          if (sub_busak_n) w_st_nxt = ST_RUN;
      endcase
    end
    w_busrq_n = !(w_st_nxt == ST_REQ ||
                  w_st_nxt == ST_HALTED);
    w_halted  = w_st_nxt == ST_HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= ST_RUN;
      r_busrq_n <= 1'b1;
      r_halted  <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_busrq_n <= w_busrq_n;
      r_halted  <= w_halted;
    end
  end

  logic          w_mwr, w_we0, w_we1, w_col;
  logic [AW-1:0] w_a0, r_buf_addr;
  logic [DW-1:0] w_d0, r_buf_data;
  logic          r_wait;

  assign w_mwr = main_cs & main_we;
  assign w_we1 = sub_cs & sub_we;

  // live mode: a pending buffered write replaces the main port
  // for one clk; a clash with the sub port defers main instead
  always_comb begin
    w_a0  = main_addr;
    w_d0  = main_din;
    w_we0 = w_mwr & r_halted;
    w_col = 1'b0;
    if (MODE == MODE_LIVE) begin
      w_we0 = w_mwr;
      if (r_wait) begin
        w_a0  = r_buf_addr;
        w_d0  = r_buf_data;
        w_we0 = 1'b1;
      end
      w_col = w_we0 & w_we1 & (w_a0 == sub_addr);
      if (w_col) w_we0 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_wait <= 1'b0;
    else     r_wait <= w_col;
    if (w_col) begin
      r_buf_addr <= w_a0;
      r_buf_data <= w_d0;
    end
  end

  jtframe_dual_ram #(.aw(AW), .dw(DW)) u_ram (
    .clk    (clk),
    .i_addr0(w_a0),
    .i_data0(w_d0),
    .i_we0  (w_we0),
    .o_q0   (main_dout),
    .i_addr1(sub_addr),
    .i_data1(sub_din),
    .i_we1  (w_we1),
    .o_q1   (sub_dout)
  );

  logic r_nmi_last, r_nmi_n, w_nmi_set;

  assign w_nmi_set = (NMI_EDGE != 0) ?
    (main_nmi_set & ~r_nmi_last) : main_nmi_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmi_last <= 1'b0;
      r_nmi_n    <= 1'b1;
    end else begin
      r_nmi_last <= main_nmi_set;
      if (w_nmi_set)        r_nmi_n <= 1'b0;
      else if (sub_nmi_ack) r_nmi_n <= 1'b1;
    end
  end

  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_irq_last, r_irq;

  // a new request reloads rather than adds to the count
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (sub_irq_req & ~r_irq_last)
      w_cnt_nxt = LEN;
    else if (cen && r_cnt != 8'd0)
      w_cnt_nxt = r_cnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 8'd0;
      r_irq_last <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_irq_last <= sub_irq_req;
      r_irq      <= w_cnt_nxt != 8'd0;
    end
  end

  assign main_wait   = r_wait;
  assign sub_busrq_n = r_busrq_n;
  assign halted      = r_halted;
  assign sub_nmi_n   = r_nmi_n;
  assign mcu_irqmain = r_irq;

endmodule

// File: tb/tb_jtdd_mcu_share.sv
// Bench for jtdd_mcu_share: MODE 0 and MODE 1 instances
// driven together, checked against a behavioural model.
module tb_jtdd_mcu_share;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst, cen;
  logic [AW-1:0] main_addr, sub_addr;
  logic main_cs, main_we, main_halt, main_nmi_set;
  logic [DW-1:0] main_din, sub_din;
  logic sub_cs, sub_we, sub_nmi_ack, sub_irq_req;
  logic sub_busak_n;

  logic [DW-1:0] m0_dout, s0_dout, m1_dout, s1_dout;
  logic m0_wait, busrq0_n, nmi0_n, irq0, halted0;
  logic m1_wait, busrq1_n, nmi1_n, irq1, halted1;

  always #5 clk = ~clk;

  jtdd_mcu_share #(.MODE(0)) u0 (
    .clk(clk), .rst(rst), .cen(cen),
    .main_addr(main_addr), .main_cs(main_cs),
    .main_we(main_we), .main_din(main_din),
    .main_dout(m0_dout), .main_wait(m0_wait),
    .main_halt(main_halt), .main_nmi_set(main_nmi_set),
    .sub_addr(sub_addr), .sub_cs(sub_cs),
    .sub_we(sub_we), .sub_din(sub_din),
    .sub_dout(s0_dout), .sub_nmi_ack(sub_nmi_ack),
    .sub_irq_req(sub_irq_req), .sub_busak_n(sub_busak_n),
    .sub_busrq_n(busrq0_n), .sub_nmi_n(nmi0_n),
    .mcu_irqmain(irq0), .halted(halted0)
  );

  jtdd_mcu_share #(.MODE(1)) u1 (
    .clk(clk), .rst(rst), .cen(cen),
    .main_addr(main_addr), .main_cs(main_cs),
    .main_we(main_we), .main_din(main_din),
    .main_dout(m1_dout), .main_wait(m1_wait),
    .main_halt(main_halt), .main_nmi_set(main_nmi_set),
    .sub_addr(sub_addr), .sub_cs(sub_cs),
    .sub_we(sub_we), .sub_din(sub_din),
    .sub_dout(s1_dout), .sub_nmi_ack(sub_nmi_ack),
    .sub_irq_req(sub_irq_req), .sub_busak_n(sub_busak_n),
    .sub_busrq_n(busrq1_n), .sub_nmi_n(nmi1_n),
    .mcu_irqmain(irq1), .halted(halted1)
  );

  int tests = 0;
  int fails = 0;
  int ph = 0;
  int cdiv = 1;
  logic stepped_cen = 1'b0;

  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    cen = (ph % cdiv) == 0;
    stepped_cen = cen;
    @(posedge clk);
    #1;
    ph++;
  endtask

  task automatic step_cen(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!stepped_cen && n < 8);
    if (!stepped_cen) chk({tag, " cen"}, 0, 1);
  endtask

  task automatic idle();
    main_cs = 0; main_we = 0;
    sub_cs = 0; sub_we = 0;
  endtask

  task automatic rand_mem(input int iters, input bit hm);
    logic mw, sw;
    logic [7:0] em0, es0, em1, es1;
    for (int i = 0; i < iters; i++) begin
      main_cs = 1'($urandom);
      main_we = 1'($urandom);
      main_addr = 10'($urandom_range(0, 15));
      main_din = 8'($urandom);
      sub_cs = 1'($urandom);
      sub_we = 1'($urandom);
      sub_addr = 10'($urandom_range(0, 15));
      sub_din = 8'($urandom);
      mw = main_cs && main_we;
      sw = sub_cs && sub_we;
      if (mw && sw && main_addr == sub_addr) begin
        sub_we = 0;
        sw = 0;
      end
      em0 = mem0[main_addr[3:0]];
      em1 = mem1[main_addr[3:0]];
      es0 = mem0[sub_addr[3:0]];
      es1 = mem1[sub_addr[3:0]];
      if (sw) begin
        mem0[sub_addr[3:0]] = sub_din;
        mem1[sub_addr[3:0]] = sub_din;
      end
      if (mw) begin
        mem1[main_addr[3:0]] = main_din;
        if (hm) mem0[main_addr[3:0]] = main_din;
      end
      step();
      if (main_cs && !(sw && sub_addr == main_addr)) begin
        chk("rnd m0 rd", m0_dout, em0);
        chk("rnd m1 rd", m1_dout, em1);
      end
      if (sub_cs && !(mw && main_addr == sub_addr)) begin
        chk("rnd s0 rd", s0_dout, es0);
        chk("rnd s1 rd", s1_dout, es1);
      end
      chk("rnd m1 wait", m1_wait, 0);
    end
    idle();
  endtask

  initial begin
    int ticks, n;
    logic nm, prev, s, a;
    rst = 1; cen = 0;
    main_addr = 0; main_cs = 0; main_we = 0; main_din = 0;
    main_halt = 0; main_nmi_set = 0;
    sub_addr = 0; sub_cs = 0; sub_we = 0; sub_din = 0;
    sub_nmi_ack = 0; sub_irq_req = 0; sub_busak_n = 1;
    step(); step();
    chk("rst busrq0", busrq0_n, 1);
    chk("rst busrq1", busrq1_n, 1);
    chk("rst nmi0", nmi0_n, 1);
    chk("rst irq0", irq0, 0);
    chk("rst halted0", halted0, 0);
    chk("rst wait0", m0_wait, 0);
    chk("rst wait1", m1_wait, 0);
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      sub_cs = 1; sub_we = 1;
      sub_addr = 10'(i);
      sub_din = 8'($urandom);
      mem0[i] = sub_din;
      mem1[i] = sub_din;
      step();
    end
    idle();
    rand_mem(40, 1'b0);

    sub_cs = 1; sub_we = 1;
    sub_addr = 10'h012; sub_din = 8'h33;
    step();
    idle();
    main_cs = 1; main_we = 1;
    main_addr = 10'h012; main_din = 8'h5A;
    step();
    idle();
    sub_cs = 1; sub_addr = 10'h012;
    step();
    chk("run drop s0", s0_dout, 8'h33);
    chk("run live s1", s1_dout, 8'h5A);
    idle();

    cdiv = 4;
    main_halt = 1;
    step_cen("hs1");
    chk("hs req busrq", busrq0_n, 0);
    chk("hs req halted", halted0, 0);
    step_cen("hs2");
    chk("hs wait busrq", busrq0_n, 0);
    chk("hs wait halted", halted0, 0);
    sub_busak_n = 0;
    step_cen("hs3");
    chk("hs halted0", halted0, 1);
    chk("hs halted1", halted1, 1);
    chk("hs halt busrq", busrq0_n, 0);
    cdiv = 1;

    main_cs = 1; main_we = 1;
    main_addr = 10'h012; main_din = 8'h5A;
    step();
    idle();
    sub_cs = 1; sub_addr = 10'h012;
    step();
    chk("halt commit s0", s0_dout, 8'h5A);
    idle();
    rand_mem(40, 1'b1);

    sub_cs = 1; sub_we = 1;
    sub_addr = 10'h105; sub_din = 8'h66;
    step();
    main_cs = 1; main_we = 1;
    main_addr = 10'h100; main_din = 8'h22;
    sub_addr = 10'h100; sub_din = 8'h11;
    step();
    chk("col wait1", m1_wait, 1);
    chk("col wait0", m0_wait, 0);
    idle();
    step();
    chk("col wait end", m1_wait, 0);
    sub_cs = 1; sub_addr = 10'h100;
    step();
    chk("col final", s1_dout, 8'h22);
    idle();

    main_cs = 1; main_we = 1;
    main_addr = 10'h101; main_din = 8'h44;
    sub_cs = 1; sub_we = 1;
    sub_addr = 10'h102; sub_din = 8'h55;
    step();
    chk("diff wait", m1_wait, 0);
    idle();
    main_cs = 1; main_addr = 10'h102;
    sub_cs = 1; sub_addr = 10'h101;
    step();
    chk("diff m1", m1_dout, 8'h55);
    chk("diff s1", s1_dout, 8'h44);
    chk("diff m0", m0_dout, 8'h55);
    chk("diff s0", s0_dout, 8'h44);
    idle();

    main_cs = 1; main_we = 1;
    main_addr = 10'h104; main_din = 8'h02;
    sub_cs = 1; sub_we = 1;
    sub_addr = 10'h104; sub_din = 8'h01;
    step();
    idle();
    main_cs = 1; main_we = 1;
    main_addr = 10'h105; main_din = 8'h77;
    step();
    idle();
    main_cs = 1; main_addr = 10'h104;
    sub_cs = 1; sub_addr = 10'h105;
    step();
    chk("hold commit", m1_dout, 8'h02);
    chk("hold ignore", s1_dout, 8'h66);
    idle();

    cdiv = 4;
    main_halt = 0;
    step_cen("rel1");
    chk("rel halted", halted0, 0);
    chk("rel busrq", busrq0_n, 1);
    main_halt = 1;
    step_cen("rel2");
    chk("rel hold busrq", busrq0_n, 1);
    sub_busak_n = 1;
    step_cen("rel3");
    chk("rel run busrq", busrq0_n, 1);
    step_cen("rel4");
    chk("rereq busrq", busrq0_n, 0);
    main_halt = 0;
    step_cen("rel5");
    chk("rereq drop", busrq0_n, 1);

    main_nmi_set = 1;
    step();
    chk("nmi set", nmi0_n, 0);
    main_nmi_set = 0;
    step();
    chk("nmi hold", nmi0_n, 0);
    main_nmi_set = 1; sub_nmi_ack = 1;
    step();
    chk("nmi set wins", nmi0_n, 0);
    main_nmi_set = 0;
    step();
    chk("nmi ack", nmi0_n, 1);
    sub_nmi_ack = 0;
    nm = 0; prev = 0;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 3) == 0);
      main_nmi_set = s;
      sub_nmi_ack = a;
      if (s && !prev) nm = 1;
      else if (a) nm = 0;
      prev = s;
      step();
      chk("nmi rnd0", nmi0_n, !nm);
      chk("nmi rnd1", nmi1_n, !nm);
    end
    main_nmi_set = 0; sub_nmi_ack = 0;
    step();

    sub_irq_req = 1;
    step();
    sub_irq_req = 0;
    chk("irq start", irq0, 1);
    ticks = 0; n = 0;
    while (irq0 && n < 100) begin
      step();
      if (stepped_cen) ticks++;
      n++;
    end
    chk("irq ended", irq0, 0);
    chk("irq ticks", ticks, 8);

    sub_irq_req = 1;
    step();
    sub_irq_req = 0;
    ticks = 0; n = 0;
    while (ticks < 5 && n < 100) begin
      step();
      if (stepped_cen) ticks++;
      n++;
    end
    chk("irq mid", irq1, 1);
    sub_irq_req = 1;
    step();
    sub_irq_req = 0;
    if (stepped_cen) ticks++;
    n = 0;
    while (irq0 && n < 100) begin
      step();
      if (stepped_cen) ticks++;
      n++;
    end
    chk("retrig ended", irq0, 0);
    chk("retrig ticks", ticks, 13);

    cdiv = 1;
    main_halt = 1;
    step();
    chk("mid req", busrq0_n, 0);
    sub_irq_req = 1; main_nmi_set = 1;
    step();
    sub_irq_req = 0; main_nmi_set = 0;
    chk("mid irq", irq0, 1);
    chk("mid nmi", nmi0_n, 0);
    rst = 1;
    step();
    chk("rst2 busrq", busrq0_n, 1);
    chk("rst2 halted", halted0, 0);
    chk("rst2 nmi", nmi0_n, 1);
    chk("rst2 irq", irq0, 0);
    chk("rst2 wait1", m1_wait, 0);
    rst = 0; main_halt = 0;
    step();
    chk("post rst busrq", busrq0_n, 1);
    chk("post rst irq", irq1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtdd_mcu_share.md
Name: jtdd_mcu_share

Overview:
- Parametrised shared-memory and handshake bridge between a main CPU and a sub-CPU/MCU.
- Owns: shared dual-port RAM, bus-request/halt handshake FSM, edge-latched NMI to the sub CPU, stretched IRQ from sub to main.
- Adds two things the earlier fixed bridge lacked: a live-access arbitration mode and a sized, retriggerable IRQ pulse.
- Sits between the main-CPU address decoder and the sub-CPU core wrapper; it does not contain the CPU core.

Parameters:
- AW, 10, shared RAM address width (both ports).
- DW, 8, data width.
- MODE, 0: 0 = main writes only while sub is halted; 1 = live dual access with collision arbitration.
- IRQ_LEN, 8, mcu_irqmain length in cen ticks (1..255).
- NMI_EDGE, 1: 1 = NMI set on rising edge of main_nmi_set; 0 = set on level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cen  in  1  sub-CPU clock enable; times the IRQ counter and handshake FSM
- main_addr  in  AW  main-side RAM address
- main_cs  in  1  main-side RAM select
- main_we  in  1  main-side write strobe (qualified by main_cs)
- main_din  in  DW  main write data
- main_dout  out  DW  main read data
- main_wait  out  1  main access stalled (MODE 1 only; tied 0 in MODE 0)
- main_halt  in  1  main requests the sub bus
- main_nmi_set  in  1  main requests NMI to sub
- sub_addr  in  AW  sub-side RAM address
- sub_cs  in  1  sub-side RAM select
- sub_we  in  1  sub write strobe
- sub_din  in  DW  sub write data
- sub_dout  out  DW  sub read data
- sub_nmi_ack  in  1  sub clears pending NMI
- sub_irq_req  in  1  sub requests IRQ to main (write strobe)
- sub_busak_n  in  1  bus acknowledge from sub core
- sub_busrq_n  out  1  bus request to sub core
- sub_nmi_n  out  1  NMI to sub core
- mcu_irqmain  out  1  stretched IRQ to main
- halted  out  1  sub bus granted to main

Behaviour:
- Reset values: sub_busrq_n=1, sub_nmi_n=1, mcu_irqmain=0, halted=0, main_wait=0. The FSM goes to RUN. RAM contents are not cleared. Reset mid-handshake aborts to RUN in one clk.
- RAM: both ports synchronous read, 1-clk latency. Read data is valid the clk after cs; read-during-write on the same port returns old data.
- Handshake FSM (advances only on cen):
  - RUN -> REQ when main_halt=1; sub_busrq_n=0 in REQ.
  - REQ -> HALTED when sub_busak_n=0.
  - REQ -> RUN if main_halt drops before ack.
  - HALTED: halted=1. -> RELEASE when main_halt=0.
  - RELEASE: sub_busrq_n=1. -> RUN when sub_busak_n=1.
  - main_halt reasserted in RELEASE: wait for RUN, then re-request.
- MODE 0 writes: main write is committed only when halted=1; otherwise it is silently dropped. Reads are always allowed. Sub writes are always committed.
- MODE 1 writes: both ports write freely.
  - Same-address writes in the same clk: the sub write is committed; the main write is held in a one-entry buffer with main_wait=1 for exactly 1 clk, then committed.
  - A new main access while main_wait=1 is ignored; main must hold.
- NMI latch:
  - Set on the main_nmi_set rising edge (NMI_EDGE=1; edge detected with a registered copy) or on level (NMI_EDGE=0).
  - Cleared by sub_nmi_ack. Set and clear in the same clk: set wins.
  - sub_nmi_n = ~latch, registered.
- IRQ to main:
  - Rising edge of sub_irq_req loads an 8-bit counter with IRQ_LEN; mcu_irqmain=1 while counter!=0.
  - The counter decrements on cen. A retrigger while active reloads it to IRQ_LEN (no accumulation).
- All outputs are registered except the RAM read data (RAM output register).

Decomposition:
- Shared package jtdd_mcu_pkg:
  - FSM state encoding (RUN=0, REQ=1, HALTED=2, RELEASE=3).
  - MODE_HALT / MODE_LIVE constants.
- Sub-module: jtframe_dual_ram (aw=AW, dw=DW) for storage.
- FSM, NMI latch, IRQ stretcher and the MODE 1 collision buffer are inline.

Test Plan:
- Handshake: rst, then main_halt=1; core answers sub_busak_n=0 two cen later -> sub_busrq_n=0 on the first cen, halted=1 one cen after ack. Drop main_halt -> RELEASE, then RUN once busak_n=1.
- MODE 0 gating: main writes 0x5A to 0x012 while running -> sub reads old value. Repeat while halted -> sub reads 0x5A one clk after address.
- MODE 1 collision: both write 0x100 in the same clk (sub 0x11, main 0x22) -> main_wait=1 for 1 clk; final content 0x22. Different addresses -> no wait, both committed.
- NMI: pulse main_nmi_set -> sub_nmi_n=0 next clk. sub_nmi_ack and a new set edge in the same clk -> sub_nmi_n stays 0. Ack alone -> sub_nmi_n=1.
- IRQ: IRQ_LEN=8, cen every 4 clk, pulse sub_irq_req -> mcu_irqmain high for 8 cen ticks (32 clk). Retrigger at tick 5 -> high for 13 ticks total.
- Reset mid-REQ and mid-IRQ pulse -> all outputs at reset values next clk; FSM in RUN.
